// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write scheduler.
package regfile_ctrl_pkg;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input writeback arbiter: round-robin by default, load-first fixed
// priority when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant        = 2'b00;
        grant_idx    = 1'b0;
        last_grant_d = last_grant_q;
`ifdef ARB_FIXED_PRIO_EN
        if (req[1]) begin
            grant     = 2'b10;
            grant_idx = 1'b1;
        end else if (req[0]) begin
            grant     = 2'b01;
            grant_idx = 1'b0;
        end
`else
        // On contention the requester that did not win last time goes next.
        if (req == 2'b11) begin
            grant_idx = ~last_grant_q;
            grant     = grant_idx ? 2'b10 : 2'b01;
        end else if (req[1]) begin
            grant     = 2'b10;
            grant_idx = 1'b1;
        end else if (req[0]) begin
            grant     = 2'b01;
            grant_idx = 1'b0;
        end
`endif
        if (|req) begin
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between ALU and load writeback and keeps
// a per-register outstanding-write scoreboard. ARB_FIXED_PRIO_EN selects load-first arbitration.
module regfile_write_scheduler
    import regfile_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_valid,
    input  logic [REG_AW-1:0]   alloc_reg,
    output logic                alloc_ready,
    input  logic [REG_AW-1:0]   rd_addr1,
    input  logic [REG_AW-1:0]   rd_addr2,
    output logic                stall,
    input  logic                req0_valid,
    input  logic [REG_AW-1:0]   req0_reg,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [REG_AW-1:0]   req1_reg,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    output logic                reg_write,
    output logic [REG_AW-1:0]   write_reg,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] pending
);
    logic [1:0]    grant;
    logic          grant_idx;
    logic          reg_write_q,  reg_write_d;
    reg_addr_t     write_reg_q,  write_reg_d;
    word_t         write_data_q, write_data_d;
    cnt_t          cnt_q [NUM_REGS];
    cnt_t          cnt_d [NUM_REGS];
    logic          alloc_fire;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1_valid, req0_valid}),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        reg_write_d  = |grant;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (grant_idx && grant[1]) begin
            write_reg_d  = req1_reg;
            write_data_d = req1_data;
        end else if (grant[0]) begin
            write_reg_d  = req0_reg;
            write_data_d = req0_data;
        end
    end

    assign alloc_ready = (cnt_q[alloc_reg] != CNT_MAX);
    assign alloc_fire  = alloc_valid && alloc_ready;

    // The decrement lands on the same edge the register file commits the write.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i]   = cnt_q[i];
            inc_vec[i] = alloc_fire && (alloc_reg == reg_addr_t'(i));
            dec_vec[i] = reg_write_q && (write_reg_q == reg_addr_t'(i));
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    assign stall      = pending[rd_addr1] | pending[rd_addr2];
    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A commit to a register with nothing outstanding is a protocol error.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        (reg_write_q && !(alloc_fire && alloc_reg == write_reg_q)) |-> pending[write_reg_q]);
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized and directed bench for regfile_write_scheduler against a behavioural model.
module tb_regfile_write_scheduler;
    import regfile_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                alloc_valid = 1'b0;
    logic [REG_AW-1:0]   alloc_reg = '0;
    logic                alloc_ready;
    logic [REG_AW-1:0]   rd_addr1 = '0;
    logic [REG_AW-1:0]   rd_addr2 = '0;
    logic                stall;
    logic                req0_valid = 1'b0;
    logic [REG_AW-1:0]   req0_reg = '0;
    logic [DATA_W-1:0]   req0_data = '0;
    logic                req0_ready;
    logic                req1_valid = 1'b0;
    logic [REG_AW-1:0]   req1_reg = '0;
    logic [DATA_W-1:0]   req1_data = '0;
    logic                req1_ready;
    logic                reg_write;
    logic [REG_AW-1:0]   write_reg;
    logic [DATA_W-1:0]   write_data;
    logic [NUM_REGS-1:0] pending;

    regfile_write_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_valid (alloc_valid),
        .alloc_reg   (alloc_reg),
        .alloc_ready (alloc_ready),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .stall       (stall),
        .req0_valid  (req0_valid),
        .req0_reg    (req0_reg),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_reg    (req1_reg),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: outstanding count per register, last winner, output stage.
    int m_cnt [NUM_REGS];
    int m_last;
    bit m_rw;
    int m_wr;
    int m_wd;

    logic obs_g0, obs_g1, obs_stall, obs_aready, obs_rw;
    logic [31:0] obs_wr, obs_wd, obs_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant(input bit v0, input bit v1);
`ifdef ARB_FIXED_PRIO_EN
        if (v1) return 1;
        if (v0) return 0;
        return -1;
`else
        if (v0 && v1) return (m_last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
        m_last = 1;
        m_rw   = 0;
        m_wr   = 0;
        m_wd   = 0;
    endtask

    task automatic drive_idle();
        alloc_valid = 1'b0;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit av, input int ar, input int ra1, input int ra2,
                        input bit v0, input int r0, input int d0,
                        input bit v1, input int r1, input int d1);
        int  g;
        int  ex_pend;
        bit  aok;
        bit  inc, dec;
        @(negedge clk);
        alloc_valid = av;
        alloc_reg   = reg_addr_t'(ar);
        rd_addr1    = reg_addr_t'(ra1);
        rd_addr2    = reg_addr_t'(ra2);
        req0_valid  = v0;
        req0_reg    = reg_addr_t'(r0);
        req0_data   = word_t'(d0);
        req1_valid  = v1;
        req1_reg    = reg_addr_t'(r1);
        req1_data   = word_t'(d1);
        #1;
        g = m_grant(v0, v1);
        ex_pend = 0;
        for (int i = 0; i < NUM_REGS; i++) if (m_cnt[i] != 0) ex_pend |= (1 << i);
        aok = (m_cnt[ar] != 3);
        chk("req0_ready",  req0_ready,  g == 0);
        chk("req1_ready",  req1_ready,  g == 1);
        chk("alloc_ready", alloc_ready, aok);
        chk("pending",     pending,     ex_pend);
        chk("stall",       stall,       ((ex_pend >> ra1) & 1) | ((ex_pend >> ra2) & 1));
        chk("reg_write",   reg_write,   m_rw);
        chk("write_reg",   write_reg,   m_wr);
        chk("write_data",  write_data,  m_wd);
        obs_g0 = req0_ready;  obs_g1 = req1_ready;  obs_stall = stall;
        obs_aready = alloc_ready;  obs_rw = reg_write;
        obs_wr = write_reg;  obs_wd = write_data;  obs_pend = pending;
        @(posedge clk);
        for (int i = 0; i < NUM_REGS; i++) begin
            inc = av && aok && (ar == i);
            dec = m_rw && (m_wr == i);
            if (inc && !dec) m_cnt[i]++;
            else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
        end
        if (g >= 0) begin
            m_rw   = 1;
            m_wr   = (g == 1) ? r1 : r0;
            m_wd   = (g == 1) ? d1 : d0;
            m_last = g;
        end else begin
            m_rw = 0;
        end
    endtask

    task automatic idle(input int ra);
        step(0, 0, ra, ra, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int exp_g1 [4];
        int cr [NUM_REGS];
        bit v0, v1;
        int r0, r1;

        m_reset();
        drive_idle();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_reg_write",  reg_write,  0);
        chk("rst_write_reg",  write_reg,  0);
        chk("rst_write_data", write_data, 0);
        chk("rst_pending",    pending,    0);
        chk("rst_alloc_ready", alloc_ready, 1);
        reset = 1'b0;

        // Contention straight out of reset.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_FIXED_PRIO_EN
        exp_g1 = '{1, 1, 1, 1};
`else
        exp_g1 = '{0, 1, 0, 1};
`endif
        for (int c = 0; c < 4; c++) begin
            step(1, 1, 0, 0, 1, 0, 16'h1000 + c, 1, 1, 16'h2000 + c);
            chk("cont_gnt1", obs_g1, exp_g1[c]);
            chk("cont_gnt0", obs_g0, !exp_g1[c]);
        end
        idle(0);

        // Single ALU request.
        step(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 16'h1234, 0, 0, 0);
        chk("single_ready", obs_g0, 1);
        idle(0);
        chk("single_rw", obs_rw, 1);
        chk("single_wr", obs_wr, 2);
        chk("single_wd", obs_wd, 16'h1234);

        // RAW hazard on register 3.
        step(1, 3, 3, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 0, 0, 0, 1, 3, 16'hbeef);
        chk("haz_n_grant", obs_g1, 1);
        chk("haz_n_stall", obs_stall, 1);
        idle(3);
        chk("haz_n1_stall", obs_stall, 1);
        idle(3);
        chk("haz_n2_stall", obs_stall, 0);
        chk("haz_n2_pend3", obs_pend[3], 0);

        // Reset while a write is in flight.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 16'h5a5a, 0, 0, 0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre_rst_rw", reg_write, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rw", reg_write, 0);
        chk("mid_rst_pend", pending, 0);
        chk("mid_rst_aready", alloc_ready, 1);
        m_reset();
        @(negedge clk);
        reset = 1'b0;

        // Saturation, then simultaneous alloc and commit on register 1.
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_aready", obs_aready, 0);
        step(0, 0, 0, 0, 1, 1, 16'h0101, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 1, 1, 16'h0202, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("simul_aready", obs_aready, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("simul_refill", obs_aready, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("simul_full", obs_aready, 0);

        // Random traffic; requests only target registers with uncommitted allocations.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NUM_REGS; i++)
                cr[i] = m_cnt[i] - ((m_rw && m_wr == i) ? 1 : 0);
            v0 = 0; v1 = 0;
            r0 = $urandom_range(0, NUM_REGS - 1);
            r1 = $urandom_range(0, NUM_REGS - 1);
            if ($urandom_range(0, 2) != 0 && cr[r0] > 0) begin
                v0 = 1;
                cr[r0]--;
            end
            if ($urandom_range(0, 2) != 0 && cr[r1] > 0) v1 = 1;
            step($urandom_range(0, 1), $urandom_range(0, NUM_REGS - 1),
                 $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1),
                 v0, r0, $urandom_range(0, 65535), v1, r1, $urandom_range(0, 65535));
        end
        idle(0);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
